obs_scheduler: RTL and testbench
================================

// Module: obs_scheduler
// PURPOSE
//  Owns up to N_OBS falling obstacles that share one obstacle sprite renderer.
//  Once per frame: advances every live obstacle, retires those that leave the screen, spawns new ones at pseudo-random X.
//  Every pixel clock: selects the obstacle whose box covers the next pixel and drives the renderer's X/Y/enable.
//  Sits between the VGA timing generator and the obstacle sprite renderer; collision logic feeds hit back.
// PARAMETERS
//  N_OBS      4    obstacle slots (2..8)
//  RES_X      32   sprite width, px
//  RES_Y      15   sprite height, px
//  SCREEN_H   480  visible lines
//  SPEED      2    px per frame, vertical step
//  SPAWN_GAP  60   frames between spawn attempts
// PORTS
//  clock        in   1          pixel clock
//  reset_n      in   1          asynchronous, active-low reset
//  enable       in   1          game running; low clears all slots
//  frame_tick   in   1          1-cycle pulse at start of vblank
//  hit          in   1          1-cycle collision pulse
//  hcount       in   10         current pixel column
//  vcount       in   10         current pixel line
//  obs_x        out  10         X of the selected slot, to renderer
//  obs_y        out  10         Y of the selected slot, to renderer
//  obs_en       out  1          renderer enable; a slot is selected
//  active_mask  out  N_OBS      live slots
//  passed       out  1          1-cycle pulse per obstacle retired off-screen
//  halted       out  1          set by hit; cleared when enable drops
// BEHAVIOUR
//  Reset: all outputs 0, all slots free, state IDLE, spawn counter 0, LFSR = 16'hACE1.
//  States:
//   - IDLE: wait for frame_tick; enable=1 -> UPDATE.
//   - UPDATE: one slot per cycle, idx 0..N_OBS-1.
//     - Live slot: y += speed.
//     - If old y + speed > SCREEN_H-1: free the slot and pulse passed (1 pulse per slot, cycle of that slot).
//     - After last slot -> SPAWN.
//   - SPAWN (1 cycle): spawn counter += 1.
//     - If counter == SPAWN_GAP: clear counter.
//     - If a slot is free, the lowest free index gets x = {1'b0, lfsr[8:0]} + 8 (range 8..519) and y = 0.
//     - If no slot is free, the spawn is skipped; the counter still clears.
//     - LFSR advances exactly once per SPAWN. -> IDLE.
//   - HALT: entered from any state on hit; slots frozen, rendering continues, halted=1.
//  Pixel select, registered, 1-cycle latency:
//   - Lookahead column hn = hcount+1 (10-bit wrap).
//   - Pick the lowest live index with x <= hn < x+RES_X and y <= vcount < y+RES_Y.
//   - Drive its x/y and obs_en=1 next cycle; none -> obs_en=0, obs_x/obs_y hold.
//   - Column 0 is one pixel late; harmless since x >= 8.
//  Overlap: lowest index wins; higher slots are hidden on shared pixels.
//  Simultaneous events:
//   - hit wins over frame_tick.
//   - frame_tick while not IDLE is ignored.
//   - enable low wins over all: next cycle slots cleared, counter 0, state IDLE, halted=0, obs_en=0.
//  Widths: y compare uses 11-bit sums so y+RES_Y never wraps; x+RES_X <= 551 fits 10 bits.
//  reset_n asserted mid-frame: immediate return to reset values; LFSR reseeds.
// CONFIGURATION
//  OBS_SPEEDUP_EN defined:
//   - speed starts at SPEED, +1 after every 16 passed pulses, saturates at 7.
//   - Passed counter: 4 bits, cleared with slots.
//  OBS_SPEEDUP_EN undefined: speed == SPEED constant; no counter logic.
// STRUCTURE
//  obs_pkg:
//   - state encoding IDLE/UPDATE/SPAWN/HALT
//   - SCREEN_W=640, X_MIN=8, LFSR_SEED=16'hACE1
//   - slot record {live, x[9:0], y[9:0]}
//  Sub-module obs_lfsr: 16-bit Galois LFSR, taps 16,14,13,11; advance input; state output.
//  Top: FSM, slot array, spawn counter, priority pixel selector.
// TESTING
//  1 Reset, enable=1, 60 frame_ticks -> slot0 live, y=0, x=8+lfsr[8:0] of seed step 1; active_mask=0001.
//  2 Slot at y=478, SPEED=2, frame_tick -> slot freed, passed high exactly 1 cycle, mask bit clears.
//  3 Slot0 x=100,y=50; hcount=99, vcount=50 -> next cycle obs_en=1, obs_x=100, obs_y=50; hcount=131 -> obs_en=0.
//  4 All N_OBS slots live at spawn frame -> no spawn, counter resets, LFSR advances once.
//  5 hit and frame_tick same cycle -> HALT, y values unchanged, halted=1; enable low -> all cleared next cycle.
//  6 OBS_SPEEDUP_EN: 16 passed pulses -> step becomes SPEED+1; after saturation step stays 7.

Source files
------------

// File: rtl/obs_pkg.sv
// Shared types and constants for the falling-obstacle scheduler:
// FSM encoding, slot record, screen/spawn constants and the LFSR step.
package obs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SPAWN  = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int          SCREEN_W  = 640;
  localparam int          X_MIN     = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps 16,14,13,11 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic       live;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Spawn column taken from the value the LFSR is about to advance to,
  // so each spawn attempt consumes exactly one fresh LFSR step.
  function automatic logic [9:0] spawn_x(input logic [15:0] s);
    return 10'((lfsr_step(s) & 16'h01FF) + 16'(X_MIN));
  endfunction

endpackage

// File: rtl/obs_lfsr.sv
// 16-bit Galois LFSR used to pick obstacle spawn columns.
// Steps once per cycle that advance is high; reseeds on reset.
module obs_lfsr
  import obs_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] state
);

  // advance the register by one Galois step when requested
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= LFSR_SEED;
    else if (advance) state <= lfsr_step(state);
  end

endmodule

// File: rtl/obs_scheduler.sv
// Falling-obstacle scheduler: owns N_OBS slots sharing one sprite renderer.
// Per frame: move live slots down, retire those leaving the screen, and
// every SPAWN_GAP frames place a new obstacle at a pseudo-random column.
// Per pixel: register the lowest-index slot covering the next pixel.
// Optional build macro OBS_SPEEDUP_EN: vertical step grows by 1 after every
// 16 retired obstacles, saturating at 7.
// dbg_state exposes the FSM state (IDLE=0, UPDATE=1, SPAWN=2, HALT=3).
module obs_scheduler
  import obs_pkg::*;
#(
  parameter int N_OBS     = 4,
  parameter int RES_X     = 32,
  parameter int RES_Y     = 15,
  parameter int SCREEN_H  = 480,
  parameter int SPEED     = 2,
  parameter int SPAWN_GAP = 60
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic             hit,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  output logic [9:0]       obs_x,
  output logic [9:0]       obs_y,
  output logic             obs_en,
  output logic [N_OBS-1:0] active_mask,
  output logic             passed,
  output logic             halted,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(N_OBS);
  localparam int CW = $clog2(SPAWN_GAP + 1);

  state_t          state;
  slot_t           slots [N_OBS];
  logic [IW-1:0]   idx;
  logic [CW-1:0]   spawn_cnt;
  logic [CW-1:0]   spawn_nxt;
  logic            gap_hit;
  logic [15:0]     lfsr_state;
  logic            lfsr_adv;
  logic [2:0]      speed;
  logic [10:0]     upd_sum;
  logic            upd_exit;
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic [9:0]      hn;
  logic            sel_found;
  logic [9:0]      sel_x;
  logic [9:0]      sel_y;

`ifdef OBS_SPEEDUP_EN
  logic [3:0]      pass_cnt;
`else
  assign speed = 3'(SPEED);
`endif

  assign dbg_state = state;
  assign spawn_nxt = spawn_cnt + CW'(1);
  assign gap_hit   = (spawn_nxt == CW'(SPAWN_GAP));
  // The LFSR moves once per spawn attempt, whether or not a slot was free.
  assign lfsr_adv  = enable && !hit && (state == SPAWN) && gap_hit;

  // 11-bit sum so a slot near the bottom cannot wrap back to the top
  assign upd_sum  = {1'b0, slots[idx].y} + 11'(speed);
  assign upd_exit = (upd_sum > 11'(SCREEN_H - 1));

  obs_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // live-slot mask and lowest free slot for spawning
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      active_mask[i] = slots[i].live;
      if (!slots[i].live) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // priority pixel selector on the lookahead column; lowest index wins
  always_comb begin
    hn        = hcount + 10'd1;
    sel_found = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (slots[i].live &&
          (hn >= slots[i].x) && ({1'b0, hn} < ({1'b0, slots[i].x} + 11'(RES_X))) &&
          (vcount >= slots[i].y) && ({1'b0, vcount} < ({1'b0, slots[i].y} + 11'(RES_Y)))) begin
        sel_found = 1'b1;
        sel_x     = slots[i].x;
        sel_y     = slots[i].y;
      end
    end
  end

  // frame FSM: slot movement, retirement, spawning, halt and clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      spawn_cnt <= '0;
      passed    <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < N_OBS; i++) slots[i] <= '0;
`ifdef OBS_SPEEDUP_EN
      pass_cnt  <= '0;
      speed     <= 3'(SPEED);
`endif
    end else begin
      passed <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        idx       <= '0;
        spawn_cnt <= '0;
        halted    <= 1'b0;
        for (int i = 0; i < N_OBS; i++) slots[i] <= '0;
`ifdef OBS_SPEEDUP_EN
        pass_cnt  <= '0;
        speed     <= 3'(SPEED);
`endif
      end else if (hit) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (frame_tick) begin
              state <= UPDATE;
              idx   <= '0;
            end
          end
          UPDATE: begin
            if (slots[idx].live) begin
              if (upd_exit) begin
                slots[idx].live <= 1'b0;
                passed          <= 1'b1;
`ifdef OBS_SPEEDUP_EN
                pass_cnt <= pass_cnt + 4'd1;
                if (pass_cnt == 4'd15 && speed != 3'd7) speed <= speed + 3'd1;
`endif
              end else begin
                slots[idx].y <= upd_sum[9:0];
              end
            end
            if (idx == IW'(N_OBS - 1)) state <= SPAWN;
            else idx <= idx + IW'(1);
          end
          SPAWN: begin
            if (gap_hit) begin
              spawn_cnt <= '0;
              if (free_found) begin
                slots[free_idx].live <= 1'b1;
                slots[free_idx].x    <= spawn_x(lfsr_state);
                slots[free_idx].y    <= '0;
              end
            end else begin
              spawn_cnt <= spawn_nxt;
            end
            state <= IDLE;
          end
          HALT:    state <= HALT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // registered renderer drive; position holds when nothing is selected
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      obs_en <= 1'b0;
      obs_x  <= '0;
      obs_y  <= '0;
    end else if (!enable) begin
      obs_en <= 1'b0;
    end else if (sel_found) begin
      obs_en <= 1'b1;
      obs_x  <= sel_x;
      obs_y  <= sel_y;
    end else begin
      obs_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_obs_scheduler.sv
// Directed bench for obs_scheduler. SPAWN_GAP is shortened to 40 so all
// four slots fill (spawns at frames 40/80/120/160) long before slot 0
// leaves the screen at frame 280, exercising the "all slots busy" skip.
// Expected spawn columns come from hand-stepped LFSR values:
//   step1 E270 -> x=120, step2 7138 -> 320, step3 389C -> 164,
//   step4 1C4E -> 86, step7 ED89 -> 401, step8 C2C4 -> 204.
module tb_obs_scheduler;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       frame_tick;
  logic       hit;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] obs_x;
  logic [9:0] obs_y;
  logic       obs_en;
  logic [3:0] active_mask;
  logic       passed;
  logic       halted;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pass_seen;
  int mask0_low_seen;

  obs_scheduler #(.SPAWN_GAP(40)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .hit         (hit),
    .hcount      (hcount),
    .vcount      (vcount),
    .obs_x       (obs_x),
    .obs_y       (obs_y),
    .obs_en      (obs_en),
    .active_mask (active_mask),
    .passed      (passed),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one frame: tick pulse then enough idle cycles for UPDATE+SPAWN
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (7) @(negedge clock);
    end
  endtask

  // frame with a stray second tick landing while the FSM is in UPDATE
  task automatic frames_double_tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (5) @(negedge clock);
    end
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    hcount = h;
    vcount = v;
    @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    hcount     = 10'd600;
    vcount     = 10'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // reset state
    check("rst_mask",   active_mask, 4'h0);
    check("rst_obs_en", obs_en,      1'b0);
    check("rst_obs_x",  obs_x,       10'd0);
    check("rst_obs_y",  obs_y,       10'd0);
    check("rst_passed", passed,      1'b0);
    check("rst_halted", halted,      1'b0);
    check("rst_state",  dbg_state,   2'd0);

    // first spawn exactly at the 40th frame
    enable = 1'b1;
    frames(39);
    check("pre_spawn_mask", active_mask, 4'h0);
    frames(1);
    check("spawn1_mask", active_mask, 4'h1);
    pix(10'd119, 10'd0);
    check("spawn1_en", obs_en, 1'b1);
    check("spawn1_x",  obs_x,  10'd120);
    check("spawn1_y",  obs_y,  10'd0);
    pix(10'd600, 10'd0);
    check("off_en",   obs_en, 1'b0);
    check("off_hold", obs_x,  10'd120);

    // frame 41: slot0 y=2; box edges
    frames(1);
    pix(10'd150, 10'd16);
    check("edge_in_en", obs_en, 1'b1);
    check("edge_in_y",  obs_y,  10'd2);
    pix(10'd151, 10'd16);
    check("right_out_en", obs_en, 1'b0);
    pix(10'd150, 10'd17);
    check("bottom_out_en", obs_en, 1'b0);
    pix(10'd119, 10'd1);
    check("top_out_en", obs_en, 1'b0);

    // frame 160: all four slots live, slot3 at x=86
    frames(119);
    check("full_mask", active_mask, 4'hF);
    pix(10'd85, 10'd0);
    check("slot3_en", obs_en, 1'b1);
    check("slot3_x",  obs_x,  10'd86);
    check("slot3_y",  obs_y,  10'd0);

    // frame 200: spawn attempt skipped, slot3 moved to y=80
    frames(40);
    check("skip_mask", active_mask, 4'hF);
    pix(10'd85, 10'd80);
    check("slot3_move_en", obs_en, 1'b1);
    check("slot3_move_y",  obs_y,  10'd80);

    // frame 279: slot0 at y=478
    frames(79);
    pix(10'd119, 10'd478);
    check("slot0_478_en", obs_en, 1'b1);
    check("slot0_478_y",  obs_y,  10'd478);

    // frame 280: slot0 retires with one passed pulse, then respawns
    pass_seen      = 0;
    mask0_low_seen = 0;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (passed) pass_seen++;
      if (!active_mask[0]) mask0_low_seen++;
    end
    check("passed_pulses", pass_seen, 1);
    check("mask0_cleared", (mask0_low_seen > 0), 1'b1);
    check("respawn_mask", active_mask, 4'hF);
    pix(10'd400, 10'd0);
    check("respawn_en", obs_en, 1'b1);
    check("respawn_x",  obs_x,  10'd401);
    check("respawn_y",  obs_y,  10'd0);

    // frame 281: slot0 y=2, then hit together with frame_tick
    frames(1);
    hit        = 1'b1;
    frame_tick = 1'b1;
    @(negedge clock);
    hit        = 1'b0;
    frame_tick = 1'b0;
    check("halt_flag",  halted,    1'b1);
    check("halt_state", dbg_state, 2'd3);
    frames(2);
    pix(10'd400, 10'd2);
    check("frozen_en", obs_en, 1'b1);
    check("frozen_y",  obs_y,  10'd2);
    check("frozen_mask", active_mask, 4'hF);

    // enable low clears everything next cycle
    enable = 1'b0;
    @(negedge clock);
    check("clr_mask",   active_mask, 4'h0);
    check("clr_halted", halted,      1'b0);
    check("clr_state",  dbg_state,   2'd0);
    check("clr_obs_en", obs_en,      1'b0);

    // ticks arriving during UPDATE are ignored; LFSR was not reseeded
    enable = 1'b1;
    frames_double_tick(39);
    check("dbl_pre_mask", active_mask, 4'h0);
    frames_double_tick(1);
    check("dbl_mask", active_mask, 4'h1);
    pix(10'd203, 10'd0);
    check("dbl_en", obs_en, 1'b1);
    check("dbl_x",  obs_x,  10'd204);

    // reset mid-frame: immediate return, LFSR reseeded
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    reset_n    = 1'b0;
    @(negedge clock);
    check("mid_rst_mask",  active_mask, 4'h0);
    check("mid_rst_state", dbg_state,   2'd0);
    check("mid_rst_x",     obs_x,       10'd0);
    reset_n = 1'b1;
    @(negedge clock);
    frames(40);
    check("reseed_mask", active_mask, 4'h1);
    pix(10'd119, 10'd0);
    check("reseed_en", obs_en, 1'b1);
    check("reseed_x",  obs_x,  10'd120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
